// File: rtl/tff_counter_ctrl.sv
// Drives the T inputs of an external flip-flop bank so that it counts modulo
// TC+1 up or down, with parallel load, start/stop and wrap strobe.
module tff_counter_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned TC    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] t_out,
  output logic             busy,
  output logic             tc_pulse
);

  localparam logic [WIDTH-1:0] TC_W = WIDTH'(TC);

  localparam logic [1:0] OP_START_UP   = 2'b00;
  localparam logic [1:0] OP_START_DOWN = 2'b01;
  localparam logic [1:0] OP_LOAD       = 2'b10;
  localparam logic [1:0] OP_STOP       = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    LOAD = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic             tc_q, tc_d;
  logic             busy_q;
  logic [WIDTH-1:0] inc_t, dec_t;
  logic             up_carry, dn_borrow;

  assign cmd_ready = !rst && (state_q != LOAD);
  assign busy      = busy_q;
  assign tc_pulse  = tc_q;

  // Toggle masks: bit i flips when all lower bits are 1 (increment) or 0 (decrement).
  always_comb begin
    inc_t     = '0;
    dec_t     = '0;
    up_carry  = 1'b1;
    dn_borrow = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      inc_t[i]  = up_carry;
      dec_t[i]  = dn_borrow;
      up_carry  = up_carry & q_in[i];
      dn_borrow = dn_borrow & ~q_in[i];
    end
  end

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    tc_d    = 1'b0;
    t_out   = '0;

    case (state_q)
      IDLE: t_out = '0;
      UP: begin
        if (q_in < TC_W) begin
          t_out = inc_t;
        end else begin
          t_out = q_in;
          tc_d  = (q_in == TC_W);
        end
      end
      DOWN: begin
        if (q_in == '0) begin
          t_out = TC_W;
          tc_d  = 1'b1;
        end else if (q_in <= TC_W) begin
          t_out = dec_t;
        end else begin
          t_out = q_in ^ TC_W;
        end
      end
      LOAD: begin
        t_out   = q_in ^ load_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cmd_valid && cmd_ready) begin
      case (cmd_op)
        OP_START_UP:   state_d = UP;
        OP_START_DOWN: state_d = DOWN;
        OP_LOAD: begin
          state_d = LOAD;
          load_d  = cmd_data;
        end
        OP_STOP:       state_d = IDLE;
        default:       state_d = IDLE;
      endcase
    end

    // Reset clears the bank by toggling every set bit, whatever the state.
    if (rst) begin
      t_out   = q_in;
      state_d = IDLE;
      load_d  = '0;
      tc_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      load_q  <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Bench for tff_counter_ctrl: models the 4-bit T flip-flop bank and checks each
// cycle's outputs against hand-computed expectations through a scoreboard queue.
module tb_tff_counter_ctrl;

  localparam logic [1:0] OP_UP = 2'b00;
  localparam logic [1:0] OP_DN = 2'b01;
  localparam logic [1:0] OP_LD = 2'b10;
  localparam logic [1:0] OP_ST = 2'b11;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] q_in;
  logic [3:0] t_out;
  logic       busy;
  logic       tc_pulse;

  logic       preset_en;
  logic [3:0] preset_val;
  logic [3:0] bank_q;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic [3:0] t;
    logic       busy;
    logic       tc;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  tff_counter_ctrl #(.WIDTH(4), .TC(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .q_in      (q_in),
    .t_out     (t_out),
    .busy      (busy),
    .tc_pulse  (tc_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External bank of T flip-flops (no reset of its own).
  always @(posedge clk) begin
    if (preset_en) bank_q <= preset_val;
    else           bank_q <= bank_q ^ t_out;
  end
  assign q_in = bank_q;

  task automatic cmp(input string nm, input string fld, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%b required=%b", nm, fld, act, req);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "q",         q_in,              e.q);
      cmp(e.name, "t_out",     t_out,             e.t);
      cmp(e.name, "busy",      {3'b000, busy},     {3'b000, e.busy});
      cmp(e.name, "tc_pulse",  {3'b000, tc_pulse}, {3'b000, e.tc});
      cmp(e.name, "cmd_ready", {3'b000, cmd_ready},{3'b000, e.rdy});
    end
  end

  task automatic step(input string nm, input logic r, input logic v, input logic [1:0] op,
                      input logic [3:0] d, input logic [3:0] eq, input logic [3:0] et,
                      input logic eb, input logic etc, input logic er);
    exp_t e;
    rst       = r;
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    e.name = nm; e.q = eq; e.t = et; e.busy = eb; e.tc = etc; e.rdy = er;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    preset_en  = 1'b1;
    preset_val = 4'b0110;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = OP_UP;
    cmd_data   = 4'h0;
    @(posedge clk);
    #1;
    preset_en = 1'b0;

    // Reset clears the preset bank
    //    name        rst  v   op     data   q      t      busy tc rdy
    step("rst",       1, 0, OP_UP, 4'h0, 4'h6, 4'h6, 0, 0, 0);
    step("post_rst",  0, 0, OP_UP, 4'h0, 4'h0, 4'h0, 0, 0, 1);

    // Count up through the wrap, then stop at 4
    step("up_cmd",    0, 1, OP_UP, 4'h0, 4'h0, 4'h0, 0, 0, 1);
    step("up0",       0, 0, OP_UP, 4'h0, 4'h0, 4'h1, 1, 0, 1);
    step("up1",       0, 0, OP_UP, 4'h0, 4'h1, 4'h3, 1, 0, 1);
    step("up2",       0, 0, OP_UP, 4'h0, 4'h2, 4'h1, 1, 0, 1);
    step("up3",       0, 0, OP_UP, 4'h0, 4'h3, 4'h7, 1, 0, 1);
    step("up4",       0, 0, OP_UP, 4'h0, 4'h4, 4'h1, 1, 0, 1);
    step("up5",       0, 0, OP_UP, 4'h0, 4'h5, 4'h3, 1, 0, 1);
    step("up6",       0, 1, OP_UP, 4'h0, 4'h6, 4'h1, 1, 0, 1);
    step("up7",       0, 0, OP_UP, 4'h0, 4'h7, 4'hF, 1, 0, 1);
    step("up8",       0, 0, OP_UP, 4'h0, 4'h8, 4'h1, 1, 0, 1);
    step("up9",       0, 0, OP_UP, 4'h0, 4'h9, 4'h9, 1, 0, 1);
    step("up_wrap0",  0, 0, OP_UP, 4'h0, 4'h0, 4'h1, 1, 1, 1);
    step("up_wrap1",  0, 0, OP_UP, 4'h0, 4'h1, 4'h3, 1, 0, 1);
    step("up_b2",     0, 0, OP_UP, 4'h0, 4'h2, 4'h1, 1, 0, 1);
    step("up_b3",     0, 0, OP_UP, 4'h0, 4'h3, 4'h7, 1, 0, 1);
    step("stop_at4",  0, 1, OP_ST, 4'h0, 4'h4, 4'h1, 1, 0, 1);
    step("hold5a",    0, 0, OP_UP, 4'h0, 4'h5, 4'h0, 0, 0, 1);
    step("hold5b",    0, 0, OP_UP, 4'h0, 4'h5, 4'h0, 0, 0, 1);

    // Restart, then reset collides with a START_UP at 6
    step("reup_cmd",  0, 1, OP_UP, 4'h0, 4'h5, 4'h0, 0, 0, 1);
    step("reup5",     0, 0, OP_UP, 4'h0, 4'h5, 4'h3, 1, 0, 1);
    step("rst_cmd6",  1, 1, OP_UP, 4'h0, 4'h6, 4'h6, 1, 0, 0);
    step("rst_idle0", 0, 0, OP_UP, 4'h0, 4'h0, 4'h0, 0, 0, 1);
    step("rst_idle1", 0, 0, OP_UP, 4'h0, 4'h0, 4'h0, 0, 0, 1);

    // Count down through the wrap, stop at 9
    step("dn_cmd",    0, 1, OP_DN, 4'h0, 4'h0, 4'h0, 0, 0, 1);
    step("dn0",       0, 0, OP_UP, 4'h0, 4'h0, 4'h9, 1, 0, 1);
    step("dn9",       0, 0, OP_UP, 4'h0, 4'h9, 4'h1, 1, 1, 1);
    step("dn8",       0, 0, OP_UP, 4'h0, 4'h8, 4'hF, 1, 0, 1);
    step("dn7",       0, 0, OP_UP, 4'h0, 4'h7, 4'h1, 1, 0, 1);
    step("dn6",       0, 0, OP_UP, 4'h0, 4'h6, 4'h3, 1, 0, 1);
    step("dn5",       0, 0, OP_UP, 4'h0, 4'h5, 4'h1, 1, 0, 1);
    step("dn4",       0, 0, OP_UP, 4'h0, 4'h4, 4'h7, 1, 0, 1);
    step("dn3",       0, 0, OP_UP, 4'h0, 4'h3, 4'h1, 1, 0, 1);
    step("dn2",       0, 0, OP_UP, 4'h0, 4'h2, 4'h3, 1, 0, 1);
    step("dn1",       0, 0, OP_UP, 4'h0, 4'h1, 4'h1, 1, 0, 1);
    step("dn0b",      0, 0, OP_UP, 4'h0, 4'h0, 4'h9, 1, 0, 1);
    step("dn_wrap9",  0, 1, OP_ST, 4'h0, 4'h9, 4'h1, 1, 1, 1);
    step("dn_stop8",  0, 0, OP_UP, 4'h0, 4'h8, 4'h0, 0, 0, 1);

    // Load 0011, then load 0101 while a command is offered during LOAD
    step("ld3_cmd",   0, 1, OP_LD, 4'h3, 4'h8, 4'h0, 0, 0, 1);
    step("ld3",       0, 0, OP_UP, 4'h0, 4'h8, 4'hB, 1, 0, 0);
    step("ld5_cmd",   0, 1, OP_LD, 4'h5, 4'h3, 4'h0, 0, 0, 1);
    step("ld5",       0, 1, OP_UP, 4'h0, 4'h3, 4'h6, 1, 0, 0);
    step("ld5_done",  0, 0, OP_UP, 4'h0, 4'h5, 4'h0, 0, 0, 1);
    step("ld5_hold",  0, 0, OP_UP, 4'h0, 4'h5, 4'h0, 0, 0, 1);

    // Out-of-range load, then count up: jumps to 0 without a wrap strobe
    step("ldD_cmd",   0, 1, OP_LD, 4'hD, 4'h5, 4'h0, 0, 0, 1);
    step("ldD",       0, 0, OP_UP, 4'h0, 4'h5, 4'h8, 1, 0, 0);
    step("oor_upcmd", 0, 1, OP_UP, 4'h0, 4'hD, 4'h0, 0, 0, 1);
    step("oor_up",    0, 0, OP_UP, 4'h0, 4'hD, 4'hD, 1, 0, 1);
    step("oor_up0",   0, 1, OP_ST, 4'h0, 4'h0, 4'h1, 1, 0, 1);
    step("oor_upst",  0, 0, OP_UP, 4'h0, 4'h1, 4'h0, 0, 0, 1);

    // Out-of-range load, then count down: jumps to TC without a wrap strobe
    step("ldD2_cmd",  0, 1, OP_LD, 4'hD, 4'h1, 4'h0, 0, 0, 1);
    step("ldD2",      0, 0, OP_UP, 4'h0, 4'h1, 4'hC, 1, 0, 0);
    step("oor_dncmd", 0, 1, OP_DN, 4'h0, 4'hD, 4'h0, 0, 0, 1);
    step("oor_dn",    0, 0, OP_UP, 4'h0, 4'hD, 4'h4, 1, 0, 1);
    step("oor_dn9",   0, 1, OP_ST, 4'h0, 4'h9, 4'h1, 1, 0, 1);
    step("oor_dnst",  0, 0, OP_UP, 4'h0, 4'h8, 4'h0, 0, 0, 1);

    cmd_valid = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
